// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART framed-command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_AHI,
    ST_ALO,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_FILL
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_CMD  = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_code_t;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_FILL     = 8'h02;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte watchdog: reloads on load, counts down while run is high.
// expired flags the cycle in which the count would reach zero.
module timeout_counter #(
  parameter int TIMEOUT_CLKS = 2600
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT_CLKS);
    end else if (run && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // A load in the same cycle wins over expiry.
  assign expired = run && !load && (count <= CNT_W'(1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/ADDR/LEN/payload/CHK packets from the UART receiver and
// issues single-byte writes on a ready/valid port; all outputs registered.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W       = 12,
  parameter int         TIMEOUT_CLKS = 2600,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_busy
);

  state_t            state, state_nxt;
  logic              is_fill;
  logic [7:0]        addr_hi;
  logic [7:0]        chk;
  logic [7:0]        fill_data;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        len_cnt;

  logic      done_nxt, err_nxt;
  err_code_t code_nxt;

  logic wr_take, wr_pend, to_run, expired, overrun, rx_ok;
  logic cmd_ok, chk_ok, last_fill, wr_issue, fill_go, fill_step;

  assign wr_take   = o_wr_valid && i_wr_ready;
  assign wr_pend   = o_wr_valid && !i_wr_ready;
  assign to_run    = state inside {ST_CMD, ST_AHI, ST_ALO, ST_LEN, ST_DATA, ST_CHK};
  assign overrun   = i_rx_valid &&
                     ((state == ST_FILL) || (wr_pend && (state == ST_DATA || state == ST_CHK)));
  assign rx_ok     = i_rx_valid && !overrun;
  assign cmd_ok    = (i_rx_data == CMD_WRITE) || (i_rx_data == CMD_FILL);
  assign chk_ok    = (i_rx_data == chk);
  assign last_fill = (state == ST_FILL) && wr_take && (len_cnt == 9'd1);
  assign wr_issue  = rx_ok && (state == ST_DATA) && !is_fill;
  assign fill_go   = rx_ok && (state == ST_CHK) && is_fill && chk_ok;
  assign fill_step = (state == ST_FILL) && wr_take && !i_rx_valid && (len_cnt != 9'd1);

  timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (i_rx_valid),
    .run    (to_run),
    .expired(expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_rx_valid) begin
      case (state)
        ST_IDLE: if (i_rx_data == SYNC_BYTE) state_nxt = ST_CMD;
        ST_CMD:  state_nxt = cmd_ok ? ST_AHI : ST_IDLE;
        ST_AHI:  state_nxt = ST_ALO;
        ST_ALO:  state_nxt = ST_LEN;
        ST_LEN:  state_nxt = ST_DATA;
        ST_DATA: begin
          if (overrun)                          state_nxt = ST_IDLE;
          else if (is_fill || len_cnt == 9'd1)  state_nxt = ST_CHK;
        end
        ST_CHK:  state_nxt = (!overrun && chk_ok && is_fill) ? ST_FILL : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end else if (to_run && expired) begin
      state_nxt = ST_IDLE;
    end else if (last_fill) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    code_nxt = err_code_t'(o_err_code);
    if (overrun) begin
      err_nxt  = 1'b1;
      code_nxt = ERR_OVERRUN;
    end else if (i_rx_valid) begin
      if (state == ST_CMD && !cmd_ok) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_BAD_CMD;
      end else if (state == ST_CHK) begin
        if (!chk_ok) begin
          err_nxt  = 1'b1;
          code_nxt = ERR_CHECKSUM;
        end else if (!is_fill) begin
          done_nxt = 1'b1;
        end
      end
    end else if (to_run && expired) begin
      err_nxt  = 1'b1;
      code_nxt = ERR_TIMEOUT;
    end else if (last_fill) begin
      done_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
      o_busy     <= 1'b0;
    end else begin
      o_done     <= done_nxt;
      o_err      <= err_nxt;
      o_err_code <= code_nxt;
      o_busy     <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      is_fill   <= 1'b0;
      addr_hi   <= 8'd0;
      chk       <= 8'd0;
      fill_data <= 8'd0;
      addr      <= '0;
      len_cnt   <= 9'd0;
    end else if (rx_ok) begin
      case (state)
        ST_CMD: begin
          chk     <= i_rx_data;
          is_fill <= (i_rx_data == CMD_FILL);
        end
        ST_AHI: begin
          chk     <= chk ^ i_rx_data;
          addr_hi <= i_rx_data;
        end
        ST_ALO: begin
          chk  <= chk ^ i_rx_data;
          addr <= ADDR_W'({addr_hi, i_rx_data});
        end
        ST_LEN: begin
          chk     <= chk ^ i_rx_data;
          len_cnt <= (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
        end
        ST_DATA: begin
          chk <= chk ^ i_rx_data;
          if (is_fill) begin
            fill_data <= i_rx_data;
          end else begin
            len_cnt <= len_cnt - 9'd1;
            addr    <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end else if (state == ST_FILL && wr_take) begin
      len_cnt <= len_cnt - 9'd1;
    end
  end

  // A new write may replace one being accepted this cycle; otherwise a
  // pending write is held until the handshake, even after an abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= 8'd0;
    end else if (wr_issue) begin
      o_wr_valid <= 1'b1;
      o_wr_addr  <= addr;
      o_wr_data  <= i_rx_data;
    end else if (fill_go) begin
      o_wr_valid <= 1'b1;
      o_wr_addr  <= addr;
      o_wr_data  <= fill_data;
    end else if (fill_step) begin
      o_wr_addr  <= o_wr_addr + ADDR_W'(1);
    end else if (wr_take) begin
      o_wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with write/event scoreboards.
module tb_uart_cmd_parser;

  localparam int ADDR_W = 12;
  localparam int TO     = 200;

  logic              i_clk      = 1'b0;
  logic              i_rst      = 1'b0;
  logic [7:0]        i_rx_data  = 8'd0;
  logic              i_rx_valid = 1'b0;
  logic              i_wr_ready = 1'b0;
  logic              o_wr_valid;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;
  logic              o_done;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic              o_busy;

  int tests = 0;
  int fails = 0;

  logic [19:0] exp_wr[$];
  logic [2:0]  exp_ev[$];
  logic [7:0]  pkt[$];

  int first_k, last_k, done_k;

  uart_cmd_parser #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_wr_valid(o_wr_valid),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .i_wr_ready(i_wr_ready),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_err_code(o_err_code),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    exp_wr.push_back({ADDR_W'(a), d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bit bad);
    logic [7:0] c;
    c = 8'h00;
    send_byte(8'hA5);
    foreach (pkt[k]) begin
      send_byte(pkt[k]);
      c = c ^ pkt[k];
    end
    send_byte(bad ? (c ^ 8'h01) : c);
  endtask

  task automatic drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check({tag, "_drained"}, exp_wr.size() + exp_ev.size(), 0);
    repeat (3) @(negedge i_clk);
    check({tag, "_idle"}, {31'd0, o_busy}, 0);
  endtask

  // Scoreboard side: every handshake and every done/err pulse must be expected.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_wr_valid && i_wr_ready) begin
        check("write_expected", {31'd0, exp_wr.size() != 0}, 1);
        if (exp_wr.size() != 0) check("write_addr_data", {o_wr_addr, o_wr_data}, exp_wr.pop_front());
      end
      if (o_done || o_err) begin
        check("event_expected", {31'd0, exp_ev.size() != 0}, 1);
        if (exp_ev.size() != 0)
          check("event_kind_code", o_err ? {1'b1, o_err_code} : 3'b000, exp_ev.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 i_rst = 1'b1;
    #2;
    check("reset_outputs",
          {o_wr_valid, o_done, o_err, o_busy, o_err_code, o_wr_addr, o_wr_data}, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_wr_ready = 1'b1;

    // WRITE of three bytes; chk = 01^01^00^03^41^42^43 = 43
    push_wr(12'h100, 8'h41);
    push_wr(12'h101, 8'h42);
    push_wr(12'h102, 8'h43);
    exp_ev.push_back(3'b000);
    send_byte(8'hA5);
    @(negedge i_clk);
    check("busy_after_sync", {31'd0, o_busy}, 1);
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h41);
    check("write_latency", {o_wr_valid, o_wr_addr, o_wr_data}, {1'b1, 12'h100, 8'h41});
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h43);
    drain(20, "write");

    // FILL with wrap across the top of the address space
    pkt = '{8'h02, 8'h0F, 8'hFF, 8'h04, 8'h20};
    push_wr(12'hFFF, 8'h20);
    push_wr(12'h000, 8'h20);
    push_wr(12'h001, 8'h20);
    push_wr(12'h002, 8'h20);
    exp_ev.push_back(3'b000);
    send_pkt(1'b0);
    first_k = -1; last_k = -1; done_k = -1;
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      @(negedge i_clk);
      if (o_wr_valid && i_wr_ready) begin
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (o_done) done_k = k;
    end
    check("fill_first_write", first_k, 0);
    check("fill_last_write", last_k, 3);
    check("fill_done", done_k, 4);
    drain(20, "fill");

    // Same FILL, corrupted checksum: error 1, no writes
    exp_ev.push_back(3'b101);
    send_pkt(1'b1);
    drain(20, "fill_bad_chk");

    // Bad command
    exp_ev.push_back(3'b100);
    send_byte(8'hA5); send_byte(8'h07);
    drain(20, "bad_cmd");

    // Timeout after A5 01
    exp_ev.push_back(3'b110);
    send_byte(8'hA5); send_byte(8'h01);
    repeat (TO - 20) @(negedge i_clk);
    check("no_early_timeout", exp_ev.size(), 1);
    drain(60, "timeout");

    // Overrun: second payload byte while first write is stalled
    i_wr_ready = 1'b0;
    push_wr(12'h010, 8'h55);
    exp_ev.push_back(3'b111);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h03); send_byte(8'h55);
    check("overrun_pending", {o_wr_valid, o_wr_addr, o_wr_data}, {1'b1, 12'h010, 8'h55});
    send_byte(8'h66);
    @(negedge i_clk);
    check("overrun_still_pending", {o_wr_valid, o_wr_addr, o_wr_data}, {1'b1, 12'h010, 8'h55});
    repeat (3) @(negedge i_clk);
    i_wr_ready = 1'b1;
    drain(20, "overrun");

    // FILL with LEN=0 means 256 writes
    pkt = '{8'h02, 8'h0F, 8'h80, 8'h00, 8'h3C};
    for (int i = 0; i < 256; i++) push_wr((12'hF80 + i) % 4096, 8'h3C);
    exp_ev.push_back(3'b000);
    send_pkt(1'b0);
    drain(400, "fill_256");

    // Reset mid-FILL with a stalled write
    i_wr_ready = 1'b0;
    pkt = '{8'h02, 8'h02, 8'h00, 8'h10, 8'h77};
    send_pkt(1'b0);
    repeat (2) @(negedge i_clk);
    check("fill_stalled", {o_wr_valid, o_busy, o_wr_addr, o_wr_data}, {2'b11, 12'h200, 8'h77});
    #2 i_rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {o_wr_valid, o_done, o_err, o_busy, o_err_code, o_wr_addr, o_wr_data}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_wr_ready = 1'b1;
    repeat (2) @(negedge i_clk);

    // Clean WRITE after reset
    pkt = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h99};
    push_wr(12'h300, 8'h99);
    exp_ev.push_back(3'b000);
    send_pkt(1'b0);
    drain(20, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Framed-command sequencer downstream of the 8N1 UART receiver. Consumes received bytes (`data`/`valid` pulses), parses fixed-format packets, and turns them into single-byte writes on a ready/valid write port. The write port drives the character/attribute RAM and the control registers of the 5151 video path. Reports completion and errors as one-cycle pulses for the host-status logic.

## Interface
- `ADDR_W`, 12: write-address width. The 4 KiB space covers the 80x25x2 text buffer plus registers.
- `TIMEOUT_CLKS`, 2600: idle clocks allowed between bytes of one packet before abort. Default is about 10 byte-times at 250 kHz / 9600 baud.
- `SYNC_BYTE`, 8'hA5: packet start marker.
- `i_clk  in  1`: clock.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `i_rx_data  in  8`: received byte; valid only while `i_rx_valid`.
- `i_rx_valid  in  1`: one-cycle pulse per received byte.
- `o_wr_valid  out  1`: write request.
- `o_wr_addr  out  ADDR_W`: write address.
- `o_wr_data  out  8`: write data.
- `i_wr_ready  in  1`: write accepted when `o_wr_valid && i_wr_ready`.
- `o_done  out  1`: one-cycle pulse; packet finished with good checksum.
- `o_err  out  1`: one-cycle pulse; packet aborted.
- `o_err_code  out  2`: reason code, valid with `o_err`.
  - 0: bad command.
  - 1: checksum mismatch.
  - 2: timeout.
  - 3: overrun.
- `o_busy  out  1`: high in every state except IDLE.

## Operation
- Packet format: SYNC, CMD, ADDR_HI, ADDR_LO, LEN, payload, CHK.
  - Start address = {ADDR_HI, ADDR_LO}[ADDR_W-1:0].
  - LEN=0 means 256.
  - CHK = XOR of CMD through the last payload byte.
- CMD 8'h01 (WRITE): payload is LEN bytes. Each byte is written to start+i as it arrives, i.e. streamed before the checksum is known. A checksum failure is reported only; already-issued writes stand.
- CMD 8'h02 (FILL): payload is 1 byte. After CHK is verified good, the byte is written to LEN consecutive addresses. On a bad CHK, nothing is written.
- Addresses wrap modulo 2^ADDR_W.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE goes to CMD. Any other byte is ignored silently.
  - CMD: 01/02 go to AHI. Any other value raises err code 0 and returns to IDLE.
  - AHI goes to ALO, then LEN.
  - LEN goes to DATA.
  - DATA: for WRITE, after LEN bytes go to CHK. For FILL, after 1 byte go to CHK.
  - CHK: on mismatch, raise err code 1 and go to IDLE. On match, WRITE goes to IDLE with `o_done`; FILL goes to FILL.
  - FILL: issue LEN writes, then pulse `o_done` and go to IDLE.
- Timeout: a counter reloads on every `i_rx_valid` and decrements in CMD..CHK. On reaching 0, raise err code 2 and go to IDLE. There is no timeout in IDLE or FILL.
- Overrun: a byte arrives in DATA/CHK while a write is still pending (`o_wr_valid && !i_wr_ready`), or any byte arrives in FILL.
  - Action: raise err code 3, discard the byte, go to IDLE.
  - The pending write stays asserted until accepted.
  - An in-progress FILL stops after its current handshake.
- A byte and a timeout expiry in the same cycle: the byte wins and no timeout is raised.

## Timing
- Reset values:
  - Outputs: `o_wr_valid`, `o_done`, `o_err`, `o_busy` = 0; `o_err_code`, `o_wr_addr`, `o_wr_data` = 0.
  - Internal: state = IDLE, counters = 0.
- All outputs are registered.
- WRITE: payload byte `i_rx_valid` at cycle t gives `o_wr_valid` at t+1. Addr/data stay stable until the handshake. `o_wr_valid` deasserts the cycle after acceptance.
- CHK byte at t gives `o_done`/`o_err` at t+1.
- FILL: first `o_wr_valid` at t+1 after CHK. With `i_wr_ready` held high, one write completes per cycle, so LEN writes take LEN cycles. `o_done` pulses the cycle after the last handshake.
- Asynchronous reset mid-packet or mid-FILL: a pending write is dropped immediately, with no done/err pulse.

## Structure
- Shared package `uart_cmd_pkg`:
  - State enum.
  - CMD_WRITE/CMD_FILL constants.
  - err_code enum.
  - SYNC default.
- Sub-module `timeout_counter`: load/decrement/expire, parameterised by TIMEOUT_CLKS.
- Everything else stays in one FSM module.

## Test plan
- A5 01 01 00 03 41 42 43 chk=0x01^0x01^0x00^0x03^0x41^0x42^0x43 -> writes (0x100,41),(0x101,42),(0x102,43), then `o_done`.
- A5 02 0F FF 04 20 chk good, `i_wr_ready`=1 -> writes 0xFFF, 0x000, 0x001, 0x002 all with data 20 on 4 consecutive cycles (wrap), then `o_done`.
- Same FILL with a bad chk -> `o_err` code 1, zero writes.
- A5 07 -> `o_err` code 0. A5 01 followed by a silence of TIMEOUT_CLKS -> code 2.
- WRITE with `i_wr_ready`=0 held across two payload bytes -> first write stays pending, `o_err` code 3, and that write completes once ready rises.
- Assert `i_rst` mid-FILL -> all outputs 0 asynchronously. A following clean packet parses correctly.
